// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text row buffer and the glyph ROM that consumes
// its char_out / glyph_x / glyph_y outputs.
//   CHAR_W_DEF   default character code width
//   GLYPH_W_DEF  default glyph cell width in pixels (power of two)
//   GLYPH_H_DEF  default glyph cell height in pixels
//   BLANK        blank character code (all ones) at the default width
//   row_state_t  write/clear controller states
//   in_range()   half-open interval test lo <= v < hi
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int CHAR_W_DEF  = 6;
    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 10;

    localparam logic [CHAR_W_DEF-1:0] BLANK = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } row_state_t;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/text_row_buf_if.sv
// ---------------------------------------------------------------------------
// text_row_buf_if
// Write / clear bus of the text row buffer.
//   wr_valid, wr_ready   write handshake (accepted when both high)
//   wr_col, wr_char      target column and character code
//   clr_req, clr_busy    clear request pulse and clear-in-progress flag
//   wr_auto              (TEXT_ROW_BUF_CURSOR_EN only) write at the cursor
// Modports: master drives requests, slave (the buffer) answers.
// COLS / CHAR_W must match the text_row_buf instance.
// ---------------------------------------------------------------------------
interface text_row_buf_if #(
    parameter int COLS   = 32,
    parameter int CHAR_W = text_pkg::CHAR_W_DEF
);
    import text_pkg::*;

    localparam int COL_W = $clog2(COLS);

    logic              wr_valid;
    logic              wr_ready;
    logic [COL_W-1:0]  wr_col;
    logic [CHAR_W-1:0] wr_char;
    logic              clr_req;
    logic              clr_busy;
`ifdef TEXT_ROW_BUF_CURSOR_EN
    logic              wr_auto;
`endif

    modport master (
`ifdef TEXT_ROW_BUF_CURSOR_EN
        output wr_auto,
`endif
        output wr_valid,
        output wr_col,
        output wr_char,
        output clr_req,
        input  wr_ready,
        input  clr_busy
    );

    modport slave (
`ifdef TEXT_ROW_BUF_CURSOR_EN
        input  wr_auto,
`endif
        input  wr_valid,
        input  wr_col,
        input  wr_char,
        input  clr_req,
        output wr_ready,
        output clr_busy
    );

endinterface

// File: rtl/text_row_mem.sv
// ---------------------------------------------------------------------------
// text_row_mem
// COLS x CHAR_W register array, one write port and one registered read port.
// A read and a write of the same column on one edge returns the old value.
// Cells carry no reset; the owner blanks them through the write port.
//   clk     clock
//   we      write enable
//   waddr   write column,  wdata  write data
//   raddr   read column,   rdata  registered read data
// ---------------------------------------------------------------------------
module text_row_mem
    import text_pkg::*;
#(
    parameter int COLS   = 32,
    parameter int CHAR_W = CHAR_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(COLS)-1:0]  waddr,
    input  logic [CHAR_W-1:0]        wdata,
    input  logic [$clog2(COLS)-1:0]  raddr,
    output logic [CHAR_W-1:0]        rdata
);

    logic [CHAR_W-1:0] mem [COLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_row_buf.sv
// ---------------------------------------------------------------------------
// text_row_buf
// One row of COLS character cells overlaid on the pixel raster. For every
// pixel it returns (one cycle later) the character under it and the pixel's
// offset inside the glyph cell; a write/clear bus updates the row.
// Leaving reset blanks the whole row over COLS cycles.
// Optional feature macro: TEXT_ROW_BUF_CURSOR_EN (auto-increment cursor,
// wr_auto on the bus and cursor_hit output).
//   clk, rst     pixel clock, synchronous active-high reset
//   bus          text_row_buf_if.slave write / clear bus
//   xcoor,ycoor  current pixel position
//   char_out     character at the pixel (BLANK outside the row)
//   glyph_x/y    pixel offset inside the cell (0 outside the row)
//   char_valid   pixel lies inside the row window
//   cursor_hit   (cursor build) displayed column equals the cursor
// ---------------------------------------------------------------------------
module text_row_buf
    import text_pkg::*;
#(
    parameter int COLS    = 32,
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int GLYPH_W = GLYPH_W_DEF,
    parameter int GLYPH_H = GLYPH_H_DEF,
    parameter int X_START = 0,
    parameter int Y_START = 100
) (
    input  logic              clk,
    input  logic              rst,
    text_row_buf_if.slave     bus,
    input  logic [9:0]        xcoor,
    input  logic [8:0]        ycoor,
    output logic [CHAR_W-1:0] char_out,
    output logic [2:0]        glyph_x,
    output logic [3:0]        glyph_y,
`ifdef TEXT_ROW_BUF_CURSOR_EN
    output logic              cursor_hit,
`endif
    output logic              char_valid
);

    localparam int COL_W = $clog2(COLS);
    localparam int X_END = X_START + COLS * GLYPH_W;
    localparam int Y_END = Y_START + GLYPH_H;

    // Blank code at this instance's width (the package constant is sized
    // for the default width only).
    localparam logic [CHAR_W-1:0] BLANK_C = '1;

    row_state_t        state_q, state_d;
    logic [COL_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              wr_accept;
    logic [COL_W-1:0]  wr_addr;

    logic              mem_we;
    logic [COL_W-1:0]  mem_waddr;
    logic [CHAR_W-1:0] mem_wdata;

    int                x_i, y_i;
    logic              in_win;
    logic [COL_W-1:0]  col_c;
    logic [2:0]        gx_c;
    logic [3:0]        gy_c;

    logic              vld_p1;
    logic [2:0]        gx_p1;
    logic [3:0]        gy_p1;
    logic [CHAR_W-1:0] char_p1;

    // Writes are only taken in IDLE and never while reset is held, so the
    // restarted clear never races a stale write.
    assign wr_accept = (state_q == ST_IDLE) && !rst && bus.wr_valid;

`ifdef TEXT_ROW_BUF_CURSOR_EN
    logic [COL_W-1:0] cursor_q;
    logic             hit_p1;

    assign wr_addr = bus.wr_auto ? cursor_q : bus.wr_col;

    // Cursor wraps naturally because COLS is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            cursor_q <= '0;
        end else if (wr_accept && bus.wr_auto) begin
            cursor_q <= cursor_q + 1'b1;
        end
    end
`else
    assign wr_addr = bus.wr_col;
`endif

    // ---------------- write / clear controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr;
        mem_wdata    = bus.wr_char;
        bus.wr_ready = 1'b0;
        bus.clr_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.wr_ready = !rst;
                mem_we       = wr_accept;
                // A write in the same cycle lands before the clear begins.
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                bus.clr_busy = 1'b1;
                mem_we       = !rst;
                mem_waddr    = clr_cnt_q;
                mem_wdata    = BLANK_C;
                clr_cnt_d    = clr_cnt_q + 1'b1;
                if (clr_cnt_q == COL_W'(COLS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ---------------- stage p0: window decode ----------------
    always_comb begin
        x_i    = int'(xcoor);
        y_i    = int'(ycoor);
        in_win = in_range(x_i, X_START, X_END) && in_range(y_i, Y_START, Y_END);
        col_c  = '0;
        gx_c   = '0;
        gy_c   = '0;
        if (in_win) begin
            col_c = COL_W'((x_i - X_START) / GLYPH_W);
            gx_c  = 3'((x_i - X_START) % GLYPH_W);
            gy_c  = 4'(y_i - Y_START);
        end
    end

    text_row_mem #(
        .COLS   (COLS),
        .CHAR_W (CHAR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (col_c),
        .rdata (char_p1)
    );

    // ---------------- stage p1: registered pixel outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            gx_p1  <= '0;
            gy_p1  <= '0;
        end else begin
            vld_p1 <= in_win;
            gx_p1  <= gx_c;
            gy_p1  <= gy_c;
        end
    end

`ifdef TEXT_ROW_BUF_CURSOR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_p1 <= 1'b0;
        end else begin
            hit_p1 <= in_win && (col_c == cursor_q);
        end
    end

    assign cursor_hit = hit_p1;
`endif

    // Memory read data is not reset; masking with vld_p1 yields BLANK both
    // outside the window and straight out of reset.
    assign char_out   = vld_p1 ? char_p1 : BLANK_C;
    assign glyph_x    = gx_p1;
    assign glyph_y    = gy_p1;
    assign char_valid = vld_p1;

endmodule

// File: tb/tb_text_row_buf.sv
module tb_text_row_buf;
    import text_pkg::*;

    localparam int COLS = 32;
    localparam int CW   = 6;
    localparam int GW   = 8;
    localparam int GH   = 10;
    localparam int XS   = 0;
    localparam int YS   = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    xcoor;
    logic [8:0]    ycoor;
    logic [CW-1:0] char_out;
    logic [2:0]    glyph_x;
    logic [3:0]    glyph_y;
    logic          char_valid;
`ifdef TEXT_ROW_BUF_CURSOR_EN
    logic          cursor_hit;
`endif

    always #5 clk = ~clk;

    text_row_buf_if #(.COLS(COLS), .CHAR_W(CW)) bus ();

    text_row_buf #(
        .COLS(COLS), .CHAR_W(CW), .GLYPH_W(GW), .GLYPH_H(GH),
        .X_START(XS), .Y_START(YS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .xcoor      (xcoor),
        .ycoor      (ycoor),
        .char_out   (char_out),
        .glyph_x    (glyph_x),
        .glyph_y    (glyph_y),
`ifdef TEXT_ROW_BUF_CURSOR_EN
        .cursor_hit (cursor_hit),
`endif
        .char_valid (char_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: row contents (-1 = unknown), clear progress, cursor.
    int mem_m [COLS];
    bit busy_m;
    int clr_pos_m;
    int cursor_m;
    bit known_m;

    // Predictions for the cycle after the current edge.
    bit p_known, p_char_known;
    int p_char, p_gx, p_gy, p_vld, p_hit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        bus.wr_col   = '0;
        bus.wr_char  = '0;
`ifdef TEXT_ROW_BUF_CURSOR_EN
        bus.wr_auto  = 1'b0;
`endif
    endtask

    task automatic pix(input int x, input int y);
        xcoor = 10'(x);
        ycoor = 9'(y);
    endtask

    // One clock: check handshake, predict outputs, apply model, check outputs.
    task automatic tick();
        int xi, yi, col, addr;
        bit inwin;
        #1;
        if (known_m) begin
            chk("wr_ready", 32'(bus.wr_ready), 32'(!busy_m && !rst));
            chk("clr_busy", 32'(bus.clr_busy), 32'(busy_m));
        end
        xi = int'(xcoor);
        yi = int'(ycoor);
        inwin = (xi >= XS) && (xi < XS + COLS * GW) && (yi >= YS) && (yi < YS + GH);
        p_known = rst || known_m;
        p_char_known = 1'b1;
        p_char = 63; p_gx = 0; p_gy = 0; p_vld = 0; p_hit = 0;
        if (!rst && inwin) begin
            col    = (xi - XS) / GW;
            p_vld  = 1;
            p_gx   = (xi - XS) % GW;
            p_gy   = yi - YS;
            p_char = mem_m[col];
            p_char_known = (mem_m[col] >= 0);
            p_hit  = (col == cursor_m) ? 1 : 0;
        end
        @(posedge clk);
        if (rst) begin
            busy_m = 1'b1; clr_pos_m = 0; cursor_m = 0; known_m = 1'b1;
        end else if (known_m) begin
            if (busy_m) begin
                mem_m[clr_pos_m] = 63;
                clr_pos_m++;
                cursor_m = 0;
                if (clr_pos_m == COLS) busy_m = 1'b0;
            end else begin
                if (bus.wr_valid) begin
                    addr = int'(bus.wr_col);
`ifdef TEXT_ROW_BUF_CURSOR_EN
                    if (bus.wr_auto) begin
                        addr = cursor_m;
                        cursor_m = (cursor_m + 1) % COLS;
                    end
`endif
                    mem_m[addr] = int'(bus.wr_char);
                end
                if (bus.clr_req) begin
                    busy_m = 1'b1; clr_pos_m = 0;
                end
            end
        end
        @(negedge clk);
        if (p_known) begin
            chk("char_valid", 32'(char_valid), p_vld);
            chk("glyph_x", 32'(glyph_x), p_gx);
            chk("glyph_y", 32'(glyph_y), p_gy);
            if (p_char_known) chk("char_out", 32'(char_out), p_char);
`ifdef TEXT_ROW_BUF_CURSOR_EN
            chk("cursor_hit", 32'(cursor_hit), p_hit);
`endif
        end
    endtask

    task automatic do_write(input int col, input int ch);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 5'(col);
        bus.wr_char  = 6'(ch);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bx [5];
        int by [5];
        int bv [5];
        bx = '{255, 256, 0, 0, 0};
        by = '{100, 100, 109, 110, 99};
        bv = '{1, 0, 1, 0, 0};
        for (int i = 0; i < COLS; i++) mem_m[i] = -1;
        busy_m = 1'b0; clr_pos_m = 0; cursor_m = 0; known_m = 1'b0;

        rst = 1'b1;
        set_idle();
        pix(8, 101);
        @(negedge clk);
        repeat (3) tick();
        #1;
        chk("rst_char", 32'(char_out), 63);
        chk("rst_gx", 32'(glyph_x), 0);
        chk("rst_gy", 32'(glyph_y), 0);
        chk("rst_vld", 32'(char_valid), 0);
        chk("rst_ready", 32'(bus.wr_ready), 0);
        @(negedge clk);

        // Clear after reset lasts exactly COLS cycles.
        rst = 1'b0;
        n = 0;
        while (bus.clr_busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("clr_len", n, COLS);

        // Whole window reads blank.
        for (int x = 0; x < COLS * GW; x++) begin
            pix(x, YS + (x % GH));
            tick();
            chk("blank_row", 32'(char_out), 63);
        end

        // Column 5 holds 0x12; scan its eight pixels.
        do_write(5, 'h12);
        for (int x = 40; x < 48; x++) begin
            pix(x, 100);
            tick();
            chk("c5_char", 32'(char_out), 'h12);
            chk("c5_gx", 32'(glyph_x), x - 40);
            chk("c5_gy", 32'(glyph_y), 0);
        end

        // Window edges.
        for (int i = 0; i < 5; i++) begin
            pix(bx[i], by[i]);
            tick();
            chk("bound_vld", 32'(char_valid), bv[i]);
        end

        // Clear with a simultaneous write: write lands, then gets blanked.
        pix(24, 100);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 5'd3;
        bus.wr_char  = 6'h05;
        bus.clr_req  = 1'b1;
        tick();
        set_idle();
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 100) begin
            tick();
            if (n == 0) chk("col3_written", 32'(char_out), 5);
            n++;
        end
        chk("clr_ready_low", n, COLS);
        tick();
        chk("col3_blank", 32'(char_out), 63);

        // Same-cycle read and write of column 7.
        do_write(7, 'h01);
        pix(56, 100);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 5'd7;
        bus.wr_char  = 6'h02;
        tick();
        bus.wr_valid = 1'b0;
        chk("same_old", 32'(char_out), 1);
        tick();
        chk("same_new", 32'(char_out), 2);

`ifdef TEXT_ROW_BUF_CURSOR_EN
        for (int i = 0; i <= COLS; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_auto  = 1'b1;
            bus.wr_char  = 6'(i);
            tick();
        end
        set_idle();
        pix(0, 100);
        tick();
        chk("cur_wrap", 32'(char_out), COLS);
        for (int x = 0; x < 24; x++) begin
            pix(x, 100);
            tick();
            chk("cur_hit_scan", 32'(cursor_hit), 32'(x >= 8 && x < 16));
        end
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.wr_valid = $urandom_range(0, 1) == 1;
            bus.wr_col   = 5'($urandom_range(0, COLS - 1));
            bus.wr_char  = 6'($urandom);
            bus.clr_req  = ($urandom_range(0, 39) == 0);
`ifdef TEXT_ROW_BUF_CURSOR_EN
            bus.wr_auto  = $urandom_range(0, 2) == 0;
`endif
            if ($urandom_range(0, 4) == 0)
                pix($urandom_range(0, 1023), $urandom_range(0, 511));
            else
                pix($urandom_range(0, COLS * GW + 4), $urandom_range(YS - 2, YS + GH + 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
